multicycle_controller: RTL

Main control FSM for the multicycle RV32I core. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the enables and mux selects of the shared datapath (PC, IR, register file, ALU, unified memory), and drives `immsrc` to the immediate `extend` unit. It is a Moore FSM with a combinational ALU decoder and instruction-type decoder. Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

---
 rtl/multicycle_controller.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: Moore state machine plus
// combinational ALU and immediate-type decoders driving the shared datapath.
module multicycle_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       memwrite,
   output logic       irwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [2:0] alucontrol,
   output logic       regwrite,
   output logic [1:0] immsrc,
   output logic       illegal
);

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
      EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
   } state_t;

   state_t     state, state_next;
   logic       pcupdate, branch;
   logic [1:0] aluop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= FETCH;
      else          state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      pcupdate   = 1'b0;
      branch     = 1'b0;
      aluop      = 2'b00;
      adrsrc     = 1'b0;
      memwrite   = 1'b0;
      irwrite    = 1'b0;
      resultsrc  = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      regwrite   = 1'b0;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            irwrite    = 1'b1;
            alusrcb    = 2'b10;
            resultsrc  = 2'b10;
            pcupdate   = 1'b1;
            state_next = DECODE;
         end
         DECODE: begin
            // ALU computes OldPC + imm here so beq has its target ready in ALUOut
            alusrca = 2'b01;
            alusrcb = 2'b01;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECUTER;
               OP_I:         state_next = EXECUTEI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
               default: begin
                  illegal    = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            state_next = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc     = 1'b1;
            state_next = MEMWB;
         end
         MEMWB: begin
            resultsrc  = 2'b01;
            regwrite   = 1'b1;
            state_next = FETCH;
         end
         MEMWRITE: begin
            adrsrc     = 1'b1;
            memwrite   = 1'b1;
            state_next = FETCH;
         end
         EXECUTER: begin
            alusrca    = 2'b10;
            aluop      = 2'b10;
            state_next = ALUWB;
         end
         EXECUTEI: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            aluop      = 2'b10;
            state_next = ALUWB;
         end
         ALUWB: begin
            regwrite   = 1'b1;
            state_next = FETCH;
         end
         BEQ: begin
            alusrca    = 2'b10;
            aluop      = 2'b01;
            branch     = 1'b1;
            state_next = FETCH;
         end
         JAL: begin
            // PC <= ALUOut (target from DECODE); ALU forms OldPC + 4 as link value
            alusrca    = 2'b01;
            alusrcb    = 2'b10;
            pcupdate   = 1'b1;
            state_next = ALUWB;
         end
         default: state_next = FETCH;
      endcase
   end

   assign pcwrite = pcupdate | (branch & zero);

   always_comb begin
      case (op)
         OP_SW:   immsrc = 2'b01;
         OP_BEQ:  immsrc = 2'b10;
         OP_JAL:  immsrc = 2'b11;
         default: immsrc = 2'b00;
      endcase
   end

   always_comb begin
      alucontrol = 3'b000;
      case (aluop)
         2'b01: alucontrol = 3'b001;
         2'b10: begin
            case (funct3)
               3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alucontrol = 3'b101;
               3'b110:  alucontrol = 3'b011;
               3'b111:  alucontrol = 3'b010;
               default: alucontrol = 3'b000;
            endcase
         end
         default: alucontrol = 3'b000;
      endcase
   end

endmodule
